// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between a core (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int MEM_WIDTH       = 32,
  parameter int DMEM_ADDR_WIDTH = 10
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_we;
  logic [DMEM_ADDR_WIDTH-1:0] req_addr;
  logic [MEM_WIDTH-1:0]       req_wdata;
  logic [MEM_WIDTH/8-1:0]     req_be;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [MEM_WIDTH-1:0]       rsp_rdata;
  logic                       rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data memory with a fixed-latency request/response handshake.
// Optional macro DMEM_ERR_CHECK_EN enables misalignment / out-of-range fault reporting.
module dmem_responder #(
  parameter int MEM_WIDTH       = 32,
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int DMEM_DEPTH      = 256,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int BYTES  = MEM_WIDTH / 8;
  localparam int WORD_W = DMEM_ADDR_WIDTH - 2;
  localparam int IDX_W  = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [3:0]           cnt;
  logic [MEM_WIDTH-1:0] mem [DMEM_DEPTH];

  logic [IDX_W-1:0]     idx_p0;
  logic                 we_p0;
  logic [MEM_WIDTH-1:0] rdata_p1;

  logic                 accept;
  logic                 enter_resp;
  logic                 req_fault;
  logic                 rd_fault;
  logic                 err_flag;
  logic [IDX_W-1:0]     req_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic                 rd_we;

  // Word index wrapped into the implemented depth.
  function automatic logic [IDX_W-1:0] word_index(input logic [WORD_W-1:0] w);
    return IDX_W'(32'(w) % 32'(DMEM_DEPTH));
  endfunction

  assign accept     = bus.req_valid && (state == S_IDLE) && !reset;
  assign req_idx    = word_index(bus.req_addr[DMEM_ADDR_WIDTH-1:2]);
  assign enter_resp = (state_n == S_RESP) && (state != S_RESP);

  // With zero wait the response is formed on the acceptance edge itself, so read from the live request.
  assign rd_idx = (state == S_IDLE) ? req_idx    : idx_p0;
  assign rd_we  = (state == S_IDLE) ? bus.req_we : we_p0;

`ifdef DMEM_ERR_CHECK_EN
  logic err_p0;

  assign req_fault = (bus.req_addr[1:0] != 2'b00) ||
                     (32'(bus.req_addr[DMEM_ADDR_WIDTH-1:2]) >= 32'(DMEM_DEPTH));
  assign rd_fault  = (state == S_IDLE) ? req_fault : err_p0;
  assign err_flag  = err_p0;

  always_ff @(posedge clk) begin
    if (accept) err_p0 <= req_fault;
  end
`else
  logic unused_lsb;

  assign unused_lsb = ^bus.req_addr[1:0];
  assign req_fault  = 1'b0;
  assign rd_fault   = 1'b0;
  assign err_flag   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (cnt == 4'd0) state_n = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.rsp_valid = (state == S_RESP);
    bus.rsp_rdata = (state == S_RESP) ? rdata_p1 : '0;
    bus.rsp_err   = (state == S_RESP) && err_flag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                cnt <= 4'd0;
    else if (accept)                          cnt <= CNT_INIT;
    else if (state == S_WAIT && cnt != 4'd0)  cnt <= cnt - 4'd1;
  end

  // ---- stage p0: request capture / store commit on the acceptance edge ----
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0 <= req_idx;
      we_p0  <= bus.req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !req_fault) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.req_be[b]) mem[req_idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
      end
    end
  end

  // ---- stage p1: response data captured on the edge entering RESP ----
  always_ff @(posedge clk) begin
    if (enter_resp) rdata_p1 <= (rd_we || rd_fault) ? '0 : mem[rd_idx];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (WAIT_CYCLES=2 and 0) sharing one expectation queue.
module tb_dmem_responder;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.MEM_WIDTH(32), .DMEM_ADDR_WIDTH(AW)) bus ();
  dmem_responder_if #(.MEM_WIDTH(32), .DMEM_ADDR_WIDTH(AW)) bus0 ();

  dmem_responder #(.MEM_WIDTH(32), .DMEM_ADDR_WIDTH(AW), .DMEM_DEPTH(256), .WAIT_CYCLES(2))
    dut (.clk(clk), .reset(reset), .bus(bus));
  dmem_responder #(.MEM_WIDTH(32), .DMEM_ADDR_WIDTH(AW), .DMEM_DEPTH(256), .WAIT_CYCLES(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [256];
  bit          written [256];

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output bit acc);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.req_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
  endtask

  // Called at the negedge after acceptance; lat counts edges from acceptance to a visible response.
  task automatic collect(output logic [31:0] rd, output logic er, output int lat, output bit got);
    got = 1'b0; lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.rsp_valid) begin
        got = 1'b1; lat = i; rd = bus.rsp_rdata; er = bus.rsp_err;
        break;
      end
      @(negedge clk);
    end
    if (got && bus.rsp_ready) @(negedge clk);
  endtask

  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rd, output logic er,
                         output int lat, output bit got);
    bit acc;
    send(we, addr, wdata, be, acc);
    if (!acc) begin
      got = 1'b0; lat = 0; rd = '0; er = 1'b0;
    end else begin
      collect(rd, er, lat, got);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state w2: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    checks++;
    if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0 || bus0.rsp_rdata !== 32'h0 || bus0.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state w0: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
               bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; bit got; exp_t e;
    logic        we_t   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [AW-1:0] ad_t [4] = '{11'h010, 11'h010, 11'h020, 11'h020};
    logic [31:0] wd_t   [4] = '{32'hDEADBEEF, 32'h0, 32'h11223344, 32'hAABBCCDD};
    logic [3:0]  be_t   [4] = '{4'hF, 4'hF, 4'hF, 4'b0101};
    logic [31:0] ex_t   [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{rdata: ex_t[i], err: 1'b0});
      run_txn(we_t[i], ad_t[i], wd_t[i], be_t[i], rd, er, lat, got);
      e = sb.pop_front();
      checks++;
      if (!got || lat != 3) begin
        errors++;
        $display("FAIL store_load_latency[%0d]: got=%0b lat=%0d required lat=3", i, got, lat);
      end
      checks++;
      if (rd !== e.rdata || er !== e.err) begin
        errors++;
        $display("FAIL store_load_data[%0d]: rdata=%h err=%b required rdata=%h err=%b", i, rd, er, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat; bit got; exp_t e;
    sb.push_back('{rdata: 32'h11BB33DD, err: 1'b0});
    run_txn(1'b0, 11'h020, 32'h0, 4'hF, rd, er, lat, got);
    e = sb.pop_front();
    checks++;
    if (!got || rd !== e.rdata || er !== e.err) begin
      errors++;
      $display("FAIL byte_enable_merge: got=%0b rdata=%h err=%b required rdata=%h err=%b", got, rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; bit got; exp_t e; bit stable;
    bus.rsp_ready = 1'b0;
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    run_txn(1'b0, 11'h010, 32'h0, 4'hF, rd, er, lat, got);
    e = sb.pop_front();
    checks++;
    if (!got || lat != 3 || rd !== e.rdata) begin
      errors++;
      $display("FAIL hold_first: got=%0b lat=%0d rdata=%h required lat=3 rdata=%h", got, lat, rd, e.rdata);
    end
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0)
        stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_stable: last valid=%b rdata=%h ready=%b required 1 %h 0",
               bus.rsp_valid, bus.rsp_rdata, bus.req_ready, e.rdata);
    end
    sb.push_back('{rdata: 32'h11BB33DD, err: 1'b0});
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 11'h020;
    bus.req_wdata = 32'h0; bus.req_be = 4'hF; bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_idle: valid=%b ready=%b required 0 1", bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL next_accept: ready=%b required 0 (accepted one edge after release)", bus.req_ready);
    end
    collect(rd, er, lat, got);
    e = sb.pop_front();
    checks++;
    if (!got || lat != 3 || rd !== e.rdata || er !== e.err) begin
      errors++;
      $display("FAIL after_hold_load: got=%0b lat=%0d rdata=%h err=%b required lat=3 rdata=%h err=%b",
               got, lat, rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit got; exp_t e;
    logic          we_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [AW-1:0] ad_t [4] = '{11'h000, 11'h012, 11'h400, 11'h000};
    logic [31:0]   wd_t [4] = '{32'hCAFEF00D, 32'h0, 32'h55555555, 32'h0};
`ifdef DMEM_ERR_CHECK_EN
    logic [31:0]   ex_t [4] = '{32'h0, 32'h0, 32'h0, 32'hCAFEF00D};
    logic          ee_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
    logic [31:0]   ex_t [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h55555555};
    logic          ee_t [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{rdata: ex_t[i], err: ee_t[i]});
      run_txn(we_t[i], ad_t[i], wd_t[i], 4'hF, rd, er, lat, got);
      e = sb.pop_front();
      checks++;
      if (!got || lat != 3 || rd !== e.rdata || er !== e.err) begin
        errors++;
        $display("FAIL addr_check[%0d]: got=%0b lat=%0d rdata=%h err=%b required lat=3 rdata=%h err=%b",
                 i, got, lat, rd, er, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; bit got; exp_t e; bit acc; bit late;
    for (int k = 0; k < 2; k++) begin
      send((k == 0), 11'h030, 32'h12345678, 4'hF, acc);
      reset = 1'b1;
      #1;
      checks++;
      if (!acc || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid[%0d]: acc=%0b valid=%b ready=%b required 0 1", k, acc, bus.rsp_valid, bus.req_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      late = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (bus.rsp_valid) late = 1'b1;
      end
      checks++;
      if (late) begin
        errors++;
        $display("FAIL reset_late_rsp[%0d]: valid seen=1 required 0", k);
      end
    end
    sb.push_back('{rdata: 32'h12345678, err: 1'b0});
    run_txn(1'b0, 11'h030, 32'h0, 4'hF, rd, er, lat, got);
    e = sb.pop_front();
    checks++;
    if (!got || lat != 3 || rd !== e.rdata) begin
      errors++;
      $display("FAIL store_survives_reset: got=%0b lat=%0d rdata=%h required lat=3 rdata=%h", got, lat, rd, e.rdata);
    end
  endtask

  task automatic test_zero_wait();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{rdata: (k == 0) ? 32'h0 : 32'hA5A55A5A, err: 1'b0});
      @(negedge clk);
      bus0.req_valid = 1'b1; bus0.req_we = (k == 0); bus0.req_addr = 11'h040;
      bus0.req_wdata = 32'hA5A55A5A; bus0.req_be = 4'hF;
      checks++;
      if (bus0.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL zero_wait_ready[%0d]: ready=%b required 1", k, bus0.req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus0.req_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== e.rdata || bus0.rsp_err !== e.err) begin
        errors++;
        $display("FAIL zero_wait_rsp[%0d]: valid=%b rdata=%h err=%b required 1 %h %b",
                 k, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err, e.rdata, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; bit got; exp_t e;
    int w; logic we; logic [31:0] d; logic [3:0] be;
    for (int i = 0; i < 24; i++) begin
      w  = 64 + $urandom_range(0, 15);
      we = !written[w] || ($urandom_range(0, 1) == 1);
      d  = $urandom;
      be = written[w] ? 4'($urandom_range(1, 15)) : 4'hF;
      sb.push_back('{rdata: we ? 32'h0 : model[w], err: 1'b0});
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
        written[w] = 1'b1;
      end
      run_txn(we, 11'(w * 4), d, be, rd, er, lat, got);
      e = sb.pop_front();
      checks++;
      if (!got || lat != 3 || rd !== e.rdata || er !== e.err) begin
        errors++;
        $display("FAIL b2b[%0d] we=%b word=%0d: got=%0b lat=%0d rdata=%h err=%b required lat=3 rdata=%h err=%b",
                 i, we, w, got, lat, rd, er, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0; bus.rsp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
    bus0.req_wdata = '0; bus0.req_be = '0; bus0.rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      model[i] = '0;
      written[i] = 1'b0;
    end
    test_reset();
    test_store_load();
    test_byte_enable();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_zero_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter MEM_WIDTH, default 32, giving the data width in bits.
REQ-002 The block SHALL have parameter DMEM_ADDR_WIDTH, default 10, giving the byte-address width.
REQ-003 The block SHALL have parameter DMEM_DEPTH, default 256, giving the number of MEM_WIDTH-bit words.
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 2, in the range 0..15, giving the added response latency.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-008 Port req_valid, input, 1 bit: the core presents a request.
REQ-009 Port req_ready, output, 1 bit: the responder accepts a request.
REQ-010 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-011 Port req_addr, input, DMEM_ADDR_WIDTH bits: byte address.
REQ-012 Port req_wdata, input, MEM_WIDTH bits: store data.
REQ-013 Port req_be, input, MEM_WIDTH/8 bits: store byte enables.
REQ-014 Port rsp_valid, output, 1 bit: a response is presented.
REQ-015 Port rsp_ready, input, 1 bit: the core accepts the response.
REQ-016 Port rsp_rdata, output, MEM_WIDTH bits: load data; 0 for stores.
REQ-017 Port rsp_err, output, 1 bit: the request faulted.

Function
REQ-018 The FSM SHALL have three states (IDLE, WAIT, RESP), and req_ready SHALL be 1 only in IDLE.
REQ-019 A request is accepted on an edge where req_valid=1 and req_ready=1; the address, we, wdata and be are registered on that edge.
REQ-020 A store SHALL write, on the acceptance edge, only the bytes whose req_be bit is 1, at word index req_addr[DMEM_ADDR_WIDTH-1:2].
REQ-021 After acceptance, the FSM SHALL go to WAIT when WAIT_CYCLES>0 and directly to RESP when WAIT_CYCLES=0.
REQ-022 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle, and the FSM SHALL enter RESP when the counter reaches 0.
REQ-023 rsp_valid SHALL first be 1 exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-024 Load data SHALL be captured into rsp_rdata on the edge that enters RESP, so a load issued after a store to the same word returns the stored bytes.
REQ-025 rsp_valid, rsp_rdata and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-026 On an edge where rsp_valid=1 and rsp_ready=1, the FSM SHALL return to IDLE, and the next request SHALL NOT be accepted earlier than the following edge.
REQ-027 A request asserted while req_ready=0 SHALL be ignored until the FSM is in IDLE, and the requester holds it.
REQ-028 rsp_valid SHALL be 0 outside RESP, and rsp_rdata SHALL be 0 whenever rsp_valid=0.

Reset
REQ-029 While reset=1, the FSM SHALL be in IDLE, the counter SHALL be 0, req_ready SHALL be 1, and rsp_valid, rsp_rdata and rsp_err SHALL be 0.
REQ-030 A reset asserted mid-transaction SHALL drop any pending response; a store accepted before the reset remains written.
REQ-031 Memory contents SHALL NOT be reset; load data from never-written words is undefined.

Configuration
REQ-032 With macro DMEM_ERR_CHECK_EN defined, a request SHALL set rsp_err=1 when req_addr[1:0]!=0 or the word index >= DMEM_DEPTH; a faulting store SHALL write nothing, and a faulting load SHALL return rsp_rdata=0.
REQ-033 Without DMEM_ERR_CHECK_EN, rsp_err SHALL be constant 0, req_addr[1:0] SHALL be ignored, and the word index SHALL wrap modulo DMEM_DEPTH.

Verification
REQ-034 Store 0xDEADBEEF to 0x010 with be=4'hF, then load 0x010 (WAIT_CYCLES=2) -> rsp_valid at acceptance+3 for each request, and the load returns rdata=0xDEADBEEF with err=0.
REQ-035 Store 0x11223344 to 0x020 with be=4'hF, then store 0xAABBCCDD with be=4'b0101, then load 0x020 -> rdata=0x11BB33DD.
REQ-036 Load response held with rsp_ready=0 for 5 cycles -> rsp_valid and rdata stay constant and req_ready=0 throughout; rsp_ready=1 -> the next request is accepted one edge later.
REQ-037 With DMEM_ERR_CHECK_EN, load 0x012 -> err=1 and rdata=0; store to word 256 -> err=1 and memory is unchanged. Without the macro, a store to word 256 aliases word 0.
REQ-038 Assert reset during WAIT of a load -> rsp_valid=0 and req_ready=1 immediately with no late response; WAIT_CYCLES=0 -> rsp_valid at acceptance+1.
